// File: rtl/vga_wr_buf_if.sv
// CPU-side bus of the video write buffer: address, data, active-low strobes and wait.
interface vga_wr_buf_if;
  logic [15:0] a;
  logic [7:0]  d;
  logic        n_we;
  logic        n_oe;
  logic        n_wait;

  modport master (output a, d, n_we, n_oe, input n_wait);
  modport slave  (input a, d, n_we, n_oe, output n_wait);
endinterface

// File: rtl/vga_wr_buf.sv
// Posted-write FIFO for the 0xE000-0xFFFF video RAMs, drained in 3-clock writes outside scanout.
// CPU is stalled only when the FIFO is full or an ext read waits for posted writes; VGA_WR_BUF_COALESCE_EN merges same-address writes.
module vga_wr_buf #(
  parameter int DEPTH_LOG2 = 3,
  parameter int GUARD      = 3
) (
  input  logic        clk,
  input  logic        n_rst,
  vga_wr_buf_if.slave cpu,
  input  logic [9:0]  hx,
  input  logic [9:0]  vy,
  output logic [12:0] buf_a,
  output logic [7:0]  buf_d,
  output logic        n_buf_oe,
  output logic        n_text_we,
  output logic        n_color_we,
  output logic        n_text_cs,
  output logic        n_color_cs
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [9:0] OK_LO = 10'(136 - GUARD);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                state_q, state_nx;
  logic [20:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, hd_nx;
  logic [CW-1:0]         count;
  logic                  ext, req, acc, full, empty, push, pop, ok, coal, sel, drain_nx;

  assign ext   = (cpu.a[15:13] == 3'b111);
  assign req   = ~cpu.n_we & ext & ~acc;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign ok    = ~((vy < 10'd480) & (hx >= OK_LO) & (hx < 10'd776));
  assign pop   = (state_q == HOLD);
  assign hd_nx = pop ? rd_ptr + PTR_ONE : rd_ptr;

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (!empty && ok) state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  state_nx = HOLD;
      HOLD:    state_nx = (count > CW'(1) && ok) ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef VGA_WR_BUF_COALESCE_EN
  logic [DEPTH_LOG2-1:0] tail_ptr;
  logic                  tail_busy;
  // The tail is off limits if it is the head being written now or the one about to be.
  always_comb begin
    tail_ptr  = wr_ptr - PTR_ONE;
    tail_busy = ((state_q != IDLE) && (tail_ptr == rd_ptr)) ||
                ((state_nx != IDLE) && (tail_ptr == hd_nx));
    coal      = req & ~empty & ~tail_busy & (mem[tail_ptr][20:8] == cpu.a[12:0]);
  end
`else
  assign coal = 1'b0;
`endif

  assign push       = req & ~coal & ~full;
  assign cpu.n_wait = ~((req & ~coal & full) | (~cpu.n_oe & ext & ~empty));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cpu.a[12:0], cpu.d};
`ifdef VGA_WR_BUF_COALESCE_EN
    if (coal) mem[tail_ptr][7:0] <= cpu.d;
`endif
  end

  assign sel      = mem[hd_nx][20];
  assign drain_nx = (state_nx != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      acc        <= 1'b0;
      buf_a      <= '0;
      buf_d      <= '0;
      n_buf_oe   <= 1'b1;
      n_text_we  <= 1'b1;
      n_color_we <= 1'b1;
      n_text_cs  <= 1'b1;
      n_color_cs <= 1'b1;
    end else begin
      state_q <= state_nx;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (cpu.n_we)         acc <= 1'b0;
      else if (push | coal) acc <= 1'b1;
      // Strobes are registered from the next state so they line up with the FSM.
      n_buf_oe   <= ~drain_nx;
      n_text_cs  <= ~(drain_nx & ~sel);
      n_color_cs <= ~(drain_nx & sel);
      n_text_we  <= ~((state_nx == STROBE) & ~sel);
      n_color_we <= ~((state_nx == STROBE) & sel);
      if (state_nx == SETUP) {buf_a, buf_d} <= mem[hd_nx];
    end
  end
endmodule

// File: tb/tb_vga_wr_buf.sv
// Directed bench for vga_wr_buf: drain timing against the VGA counters, FIFO stall, read stall, reset and coalescing.
module tb_vga_wr_buf;
  logic        clk = 1'b0;
  logic        n_rst;
  logic [9:0]  hx, vy;
  logic [12:0] buf_a;
  logic [7:0]  buf_d;
  logic        n_buf_oe, n_text_we, n_color_we, n_text_cs, n_color_cs;

  vga_wr_buf_if cpu ();

  vga_wr_buf #(.DEPTH_LOG2(3), .GUARD(3)) dut (
    .clk(clk), .n_rst(n_rst), .cpu(cpu), .hx(hx), .vy(vy),
    .buf_a(buf_a), .buf_d(buf_d), .n_buf_oe(n_buf_oe),
    .n_text_we(n_text_we), .n_color_we(n_color_we),
    .n_text_cs(n_text_cs), .n_color_cs(n_color_cs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        color;
    logic [12:0] a;
    logic [7:0]  d;
    logic [9:0]  h;
  } wr_t;

  wr_t        wlog[$];
  logic [9:0] oe_first, oe_last;
  logic       oe_seen = 1'b0;
  int         checks = 0;
  int         errors = 0;

  // hx seen here is the column the DUT sampled at the edge that produced these outputs, plus one.
  always @(negedge clk) begin
    if (!n_text_we || !n_color_we)
      wlog.push_back('{color: ~n_color_we, a: buf_a, d: buf_d, h: hx});
    if (!n_buf_oe) begin
      if (!oe_seen) begin
        oe_first = hx;
        oe_seen  = 1'b1;
      end
      oe_last = hx;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (hx == 10'd799) begin
      hx = 10'd0;
      vy = (vy == 10'd524) ? 10'd0 : vy + 10'd1;
    end else begin
      hx = hx + 10'd1;
    end
  endtask

  task automatic set_pos(input logic [9:0] v, input logic [9:0] h);
    vy = v;
    hx = h;
    #1;
  endtask

  task automatic run_to(input logic [9:0] h);
    for (int i = 0; i < 1000 && hx != h; i++) step();
  endtask

  task automatic clear_log();
    wlog.delete();
    oe_seen = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] dat,
                           output int waited, output logic [9:0] rel_hx);
    cpu.a    = addr;
    cpu.d    = dat;
    cpu.n_oe = 1'b1;
    cpu.n_we = 1'b0;
    #1;
    waited = 0;
    while (cpu.n_wait !== 1'b1 && waited < 2000) begin
      step();
      #1;
      waited++;
    end
    rel_hx = hx;
    if (waited >= 2000) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: n_wait=%b required 1", cpu.n_wait);
    end
    step();
    cpu.n_we = 1'b1;
    step();
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    cpu.a = 16'h0000; cpu.d = 8'h00; cpu.n_we = 1'b1; cpu.n_oe = 1'b1;
    hx = 10'd0; vy = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    #1;
    checks++; if (cpu.n_wait !== 1'b1)  begin errors++; $display("FAIL reset_n_wait: got %b want 1", cpu.n_wait); end
    checks++; if (n_buf_oe !== 1'b1)    begin errors++; $display("FAIL reset_n_buf_oe: got %b want 1", n_buf_oe); end
    checks++; if (n_text_we !== 1'b1)   begin errors++; $display("FAIL reset_n_text_we: got %b want 1", n_text_we); end
    checks++; if (n_color_we !== 1'b1)  begin errors++; $display("FAIL reset_n_color_we: got %b want 1", n_color_we); end
    checks++; if (n_text_cs !== 1'b1)   begin errors++; $display("FAIL reset_n_text_cs: got %b want 1", n_text_cs); end
    checks++; if (n_color_cs !== 1'b1)  begin errors++; $display("FAIL reset_n_color_cs: got %b want 1", n_color_cs); end
    checks++; if (buf_a !== 13'h0000)   begin errors++; $display("FAIL reset_buf_a: got %h want 0000", buf_a); end
    checks++; if (buf_d !== 8'h00)      begin errors++; $display("FAIL reset_buf_d: got %h want 00", buf_d); end
  endtask

  task automatic test_single_write();
    int w;
    logic [9:0] rh;
    set_pos(10'd10, 10'd200);
    clear_log();
    cpu_write(16'hE005, 8'h41, w, rh);
    checks++; if (w != 0) begin errors++; $display("FAIL single_n_wait: stalled %0d clocks want 0", w); end
    run_to(10'd790);
    checks++;
    if (wlog.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d writes want 1", wlog.size());
    end else begin
      // Decision on the edge sampling hx=776: SETUP at 777, STROBE at 778.
      checks++; if (wlog[0].h !== 10'd778)   begin errors++; $display("FAIL single_hx: strobe at %0d want 778", wlog[0].h); end
      checks++; if (wlog[0].color !== 1'b0)  begin errors++; $display("FAIL single_ram: color=%b want 0", wlog[0].color); end
      checks++; if (wlog[0].a !== 13'h0005)  begin errors++; $display("FAIL single_addr: got %h want 0005", wlog[0].a); end
      checks++; if (wlog[0].d !== 8'h41)     begin errors++; $display("FAIL single_data: got %h want 41", wlog[0].d); end
    end
  endtask

  task automatic test_fill();
    int w, wsum;
    logic [9:0] rh;
    logic [15:0] addr;
    set_pos(10'd20, 10'd150);
    clear_log();
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      addr = (i % 2 == 1) ? 16'hF000 + 16'(i * 3) : 16'hE000 + 16'(i * 3);
      cpu_write(addr, 8'h50 + 8'(i), w, rh);
      wsum += w;
    end
    checks++; if (wsum != 0) begin errors++; $display("FAIL fill_no_stall: stalled %0d clocks want 0", wsum); end
    cpu_write(16'hE000 + 16'(8 * 3), 8'h58, w, rh);
    checks++; if (w == 0) begin errors++; $display("FAIL fill_ninth_stall: stalled %0d clocks want >0", w); end
    // First pop on the edge sampling hx=779 (HOLD), so the CPU is released at hx=780.
    checks++; if (rh !== 10'd780) begin errors++; $display("FAIL fill_release_hx: got %0d want 780", rh); end
    repeat (50) step();
    checks++;
    if (wlog.size() != 9) begin
      errors++; $display("FAIL fill_count: got %0d writes want 9", wlog.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        addr = (i % 2 == 1) ? 16'hF000 + 16'(i * 3) : 16'hE000 + 16'(i * 3);
        checks++;
        if (wlog[i].a !== addr[12:0] || wlog[i].d !== 8'h50 + 8'(i) || wlog[i].color !== addr[12]) begin
          errors++;
          $display("FAIL fill_order[%0d]: got a=%h d=%h c=%b want a=%h d=%h c=%b",
                   i, wlog[i].a, wlog[i].d, wlog[i].color, addr[12:0], 8'h50 + 8'(i), addr[12]);
        end
      end
    end
  endtask

  task automatic test_boundary();
    int w;
    logic [9:0] rh;
    set_pos(10'd0, 10'd131);
    clear_log();
    cpu_write(16'hE020, 8'h5A, w, rh);
    run_to(10'd140);
    // SETUP begins on the edge sampling hx=132, so the drain occupies columns 133..135.
    checks++; if (oe_first !== 10'd133 || !oe_seen) begin errors++; $display("FAIL bound_setup: first oe at %0d want 133", oe_first); end
    checks++; if (oe_last !== 10'd135) begin errors++; $display("FAIL bound_hold_end: last oe at %0d want 135", oe_last); end
    checks++; if (wlog.size() != 1)    begin errors++; $display("FAIL bound_count: got %0d want 1", wlog.size()); end
    set_pos(10'd0, 10'd132);
    clear_log();
    cpu_write(16'hE021, 8'hA5, w, rh);
    run_to(10'd790);
    checks++; if (oe_first !== 10'd777 || !oe_seen) begin errors++; $display("FAIL bound_late: first oe at %0d want 777", oe_first); end
    checks++;
    if (wlog.size() != 1) begin errors++; $display("FAIL bound_late_count: got %0d want 1", wlog.size()); end
    else if (wlog[0].d !== 8'hA5) begin errors++; $display("FAIL bound_late_data: got %h want a5", wlog[0].d); end
  endtask

  task automatic test_read_stall();
    int w, n;
    logic [9:0] rh;
    set_pos(10'd30, 10'd200);
    clear_log();
    cpu_write(16'hE010, 8'h11, w, rh);
    cpu_write(16'hF011, 8'h22, w, rh);
    cpu.a = 16'h1234; cpu.n_oe = 1'b0; #1;
    checks++; if (cpu.n_wait !== 1'b1) begin errors++; $display("FAIL read_non_ext: n_wait=%b want 1", cpu.n_wait); end
    cpu.a = 16'hF010; #1;
    checks++; if (cpu.n_wait !== 1'b0) begin errors++; $display("FAIL read_stall: n_wait=%b want 0", cpu.n_wait); end
    n = 0;
    while (cpu.n_wait !== 1'b1 && n < 1000) begin step(); #1; n++; end
    // Second HOLD is at hx=782; the pop on that edge empties the FIFO.
    checks++; if (hx !== 10'd783) begin errors++; $display("FAIL read_release_hx: got %0d want 783", hx); end
    checks++; if (wlog.size() != 2) begin errors++; $display("FAIL read_writes_done: got %0d want 2", wlog.size()); end
    cpu.n_oe = 1'b1;
    cpu.a = 16'h0000;
    step();
  endtask

  task automatic test_reset_mid();
    int w, n;
    logic [9:0] rh;
    set_pos(10'd40, 10'd770);
    clear_log();
    cpu_write(16'hF123, 8'h77, w, rh);
    cpu_write(16'hE044, 8'h44, w, rh);
    n = 0;
    while (n_color_we !== 1'b0 && n < 100) begin step(); #1; n++; end
    checks++; if (n_color_we !== 1'b0) begin errors++; $display("FAIL rst_reach_strobe: n_color_we=%b want 0", n_color_we); end
    n_rst = 1'b0;
    #1;
    checks++; if (n_color_we !== 1'b1) begin errors++; $display("FAIL rst_color_we: got %b want 1", n_color_we); end
    checks++; if (n_text_we !== 1'b1)  begin errors++; $display("FAIL rst_text_we: got %b want 1", n_text_we); end
    checks++; if (n_buf_oe !== 1'b1)   begin errors++; $display("FAIL rst_buf_oe: got %b want 1", n_buf_oe); end
    checks++; if (n_color_cs !== 1'b1) begin errors++; $display("FAIL rst_color_cs: got %b want 1", n_color_cs); end
    step();
    step();
    n_rst = 1'b1;
    cpu.a = 16'hE000; cpu.n_oe = 1'b0; #1;
    checks++; if (cpu.n_wait !== 1'b1) begin errors++; $display("FAIL rst_empty: n_wait=%b want 1", cpu.n_wait); end
    cpu.n_oe = 1'b1;
    clear_log();
    repeat (60) step();
    checks++; if (wlog.size() != 0 || oe_seen) begin errors++; $display("FAIL rst_no_strobe: got %0d writes oe=%b want 0 0", wlog.size(), oe_seen); end
  endtask

  task automatic test_coalesce();
    int w;
    logic [9:0] rh;
    set_pos(10'd50, 10'd200);
    clear_log();
    cpu_write(16'hE100, 8'h11, w, rh);
    cpu_write(16'hE100, 8'h22, w, rh);
    run_to(10'd790);
`ifdef VGA_WR_BUF_COALESCE_EN
    checks++;
    if (wlog.size() != 1) begin errors++; $display("FAIL coal_count: got %0d want 1", wlog.size()); end
    else if (wlog[0].d !== 8'h22 || wlog[0].a !== 13'h0100) begin
      errors++; $display("FAIL coal_data: got a=%h d=%h want a=0100 d=22", wlog[0].a, wlog[0].d);
    end
`else
    checks++;
    if (wlog.size() != 2) begin errors++; $display("FAIL coal_count: got %0d want 2", wlog.size()); end
    else if (wlog[0].d !== 8'h11 || wlog[1].d !== 8'h22 || wlog[1].a !== 13'h0100) begin
      errors++; $display("FAIL coal_order: got d=%h,%h a=%h want 11,22 a=0100", wlog[0].d, wlog[1].d, wlog[1].a);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill();
    test_boundary();
    test_read_stall();
    test_reset_mid();
    test_coalesce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_wr_buf.md
# vga_wr_buf

Posted-write buffer and scheduler for the video text/colour RAMs. It accepts CPU writes to the video window (0xE000–0xFFFF) into a small FIFO. It releases the CPU after one clock instead of stalling for the whole active scan line. It drains the queued writes into the RAMs only while the scanout engine leaves them idle: horizontal/vertical blanking and the border columns. It sits between the CPU bus and the RAM strobe/bus-driver pins, and uses the VGA pixel counters to decide when the RAMs are free.

## Interface
Parameters:
- DEPTH_LOG2, 3: FIFO depth is 2^DEPTH_LOG2 entries, each 13-bit address + 8-bit data.
- GUARD, 3: clocks of lead time. No new RAM write may start when a write starting now would still be running when scanout begins.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1: pixel clock; hx advances once per clk.
  - n_rst, in, 1: asynchronous active-low reset.
- CPU side (all synchronous to clk):
  - a, in, 16: CPU address.
  - d, in, 8: CPU write data.
  - n_we, in, 1: CPU write strobe, active low.
  - n_oe, in, 1: CPU read strobe, active low.
  - n_wait, out, 1: low stalls the CPU; the CPU holds a/d/n_we/n_oe while it is low.
- Video side:
  - hx, in, 10: VGA column counter.
  - vy, in, 10: VGA line counter.
- RAM side:
  - buf_a, out, 13: RAM address driven from the buffer.
  - buf_d, out, 8: RAM data driven from the buffer.
  - n_buf_oe, out, 1: enables the buf_a/buf_d bus drivers onto the RAM buses, active low.
  - n_text_we, out, 1: text RAM write strobe, active low.
  - n_color_we, out, 1: colour RAM write strobe, active low.
  - n_text_cs, out, 1: text RAM chip select for drain cycles, active low.
  - n_color_cs, out, 1: colour RAM chip select for drain cycles, active low.

## Operation
- Decode: ext = (a[15:13] == 3'b111). a[12] = 0 selects text RAM; a[12] = 1 selects colour RAM. An entry stores {a[12:0], d}.
- Write request: n_we = 0 and ext, and not yet accepted in this access. An "accepted" flag sets on acceptance and clears when n_we returns high.
- Accept (push) at a clock edge when a request is present and the FIFO is not full.
- Full is evaluated on the registered count. A pop in the same cycle does not free a slot for that edge.
- n_wait = 0 in either case:
  - an unaccepted write request is present and the FIFO is full;
  - n_oe = 0, ext, and the FIFO is non-empty (reads wait until all posted writes land).
- Non-ext accesses never assert n_wait.
- Scan window: busy = (vy < 480) & (136 <= hx < 776).
- Start permission: ok = ~((vy < 480) & (136 − GUARD <= hx < 776)). Compare widths are 10 bits.
- Drain FSM, one clock per state:
  - IDLE → SETUP when FIFO is non-empty and ok.
  - SETUP: n_buf_oe = 0, drive buf_a/buf_d from the head entry, assert the cs selected by the entry's a[12].
  - STROBE: same as SETUP, plus the selected we = 0.
  - HOLD: we high; bus and cs held; pop the head at the end of HOLD.
  - HOLD → SETUP directly if the FIFO is still non-empty and ok; otherwise HOLD → IDLE.
- A drain in progress always completes. GUARD guarantees it ends before busy.
- Outside SETUP/STROBE/HOLD, n_buf_oe, both we and both cs are 1.
- Writes land in FIFO order. The head entry is stable from SETUP through HOLD.
- Reset mid-operation: all strobes go high at once, FIFO empties, FSM returns to IDLE, the accepted flag clears. The interrupted RAM write is lost.

## Timing
- Reset values:
  - n_wait = 1, n_buf_oe = 1, n_text_we = 1, n_color_we = 1, n_text_cs = 1, n_color_cs = 1;
  - buf_a = 0, buf_d = 0;
  - count = 0, FSM = IDLE.
- Push to earliest SETUP: 1 clock. The entry is visible the cycle after the accepting edge.
- RAM write: 3 clocks per entry. Back-to-back drain sustains 1 entry per 3 clocks.
- Per active line, the drain window is hx 776..799 and 0..(132 for GUARD = 3), i.e. 157 start slots.
- Whole lines 480..524 are free.
- All outputs are registered; n_wait is combinational from inputs and registered count.

## Configuration
- VGA_WR_BUF_COALESCE_EN defined:
  - a request whose a[12:0] equals the tail entry's address overwrites the tail data instead of pushing;
  - this applies only when the tail is not the entry currently in SETUP/STROBE/HOLD;
  - coalescing is allowed even when the FIFO is full, and then n_wait is not asserted.
- Undefined: every accepted write occupies its own entry.

## Test plan
- Single write at a = 0xE005, d = 0x41 at vy = 10, hx = 200 → n_wait stays 1. No we pulse until hx = 776. Then n_text_we pulses low for one clock with buf_a = 0x0005, buf_d = 0x41; n_color_we stays 1.
- Nine writes at DEPTH_LOG2 = 3 during the active region → n_wait goes low on the ninth and releases one clock after the first pop in blanking. The RAM write order matches issue order.
- Drain boundary at vy = 0: entry queued, window opens at hx = 132 → SETUP starts at hx = 132 and HOLD ends at hx = 135. An entry ready at hx = 133 waits until hx = 776.
- Read of 0xF010 with two queued writes → n_wait is low until the second HOLD completes, then 1. A read of 0x1234 is never stalled.
- n_rst pulsed low during STROBE → n_color_we/n_text_we/n_buf_oe go 1 immediately, count reads 0 after release, and no further strobes occur.
- COALESCE_EN: two writes to 0xE100 (0x11, then 0x22) during scan → exactly one RAM write with buf_d = 0x22. With the macro undefined, both writes occur in order.
